// File: rtl/alu_pkg.sv
// Shared definitions for the serial ALU datapath blocks: result modes,
// sequencer states and a configuration check for chunked operators.
package alu_pkg;

   localparam logic [1:0] MODE_WRAP = 2'd0;
   localparam logic [1:0] MODE_USAT = 2'd1;
   localparam logic [1:0] MODE_SSAT = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic bit chunk_fits(input int width, input int chunk);
      return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
   endfunction

endpackage

// File: rtl/restador_chunk.sv
// One CHUNK-bit slice of the serial subtractor: d = a - b - bin, with the
// borrow out taken from the sign of the one-bit-wider difference.
module restador_chunk #(
   parameter int CHUNK = 2
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             bin,
   output logic [CHUNK-1:0] d,
   output logic             bout
);

   assign {bout, d} = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bin};

endmodule

// File: rtl/restador_serial.sv
// Multi-cycle WIDTH-bit subtractor, CHUNK bits per clock, with wrap,
// unsigned-saturate and signed-saturate result modes.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | ready_o high, waiting for valid_i
// ST_BUSY | one chunk per cycle, LSB chunk first, borrow carried in brw
// ST_DONE | valid_o high, result/flags held until ack_i
module restador_serial
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] data0_i,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [1:0]       mode_i,
   output logic             valid_o,
   input  logic             ack_i,
   output logic [WIDTH-1:0] result_o,
   output logic             borrow_o,
   output logic             overflow_o,
   output logic             sat_o,
   output logic             zero_o,
   output logic             negative_o
);

   localparam int N  = WIDTH / CHUNK;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0]    K_LAST = KW'(N - 1);
   localparam logic [WIDTH-1:0] SMIN   = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] SMAX   = ~SMIN;

   generate
      if (!chunk_fits(WIDTH, CHUNK)) begin : g_bad_cfg
         $error("restador_serial: WIDTH must be a non-zero multiple of CHUNK");
      end
   endgenerate

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] raw;
   logic [KW-1:0]    k;
   logic             brw;
   logic [1:0]       mode;
   logic             a_msb;
   logic             b_msb;

   logic [CHUNK-1:0] d;
   logic             bout;
   logic [WIDTH-1:0] raw_next;
   logic             fin_ovf;
   logic [WIDTH-1:0] res_adj;
   logic             sat_adj;

   restador_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a    (a_sh[CHUNK-1:0]),
      .b    (b_sh[CHUNK-1:0]),
      .bin  (brw),
      .d    (d),
      .bout (bout)
   );

   // New chunk enters at the top; after N shifts raw holds the full difference.
   assign raw_next = WIDTH'({d, raw} >> CHUNK);
   assign fin_ovf  = (a_msb != b_msb) && (raw_next[WIDTH-1] != a_msb);

   always_comb begin
      res_adj = raw_next;
      sat_adj = 1'b0;
      case (mode)
         MODE_USAT: begin
            if (bout) begin
               res_adj = '0;
               sat_adj = 1'b1;
            end
         end
         MODE_SSAT: begin
            if (fin_ovf) begin
               res_adj = a_msb ? SMIN : SMAX;
               sat_adj = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= ST_IDLE;
         a_sh       <= '0;
         b_sh       <= '0;
         raw        <= '0;
         k          <= '0;
         brw        <= 1'b0;
         mode       <= MODE_WRAP;
         a_msb      <= 1'b0;
         b_msb      <= 1'b0;
         result_o   <= '0;
         borrow_o   <= 1'b0;
         overflow_o <= 1'b0;
         sat_o      <= 1'b0;
         zero_o     <= 1'b0;
         negative_o <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (valid_i) begin
                  a_sh  <= data0_i;
                  b_sh  <= data1_i;
                  mode  <= mode_i;
                  a_msb <= data0_i[WIDTH-1];
                  b_msb <= data1_i[WIDTH-1];
                  k     <= '0;
                  brw   <= 1'b0;
                  state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               a_sh <= a_sh >> CHUNK;
               b_sh <= b_sh >> CHUNK;
               raw  <= raw_next;
               brw  <= bout;
               k    <= k + KW'(1);
               if (k == K_LAST) begin
                  result_o   <= res_adj;
                  borrow_o   <= bout;
                  overflow_o <= fin_ovf;
                  sat_o      <= sat_adj;
                  zero_o     <= (res_adj == '0);
                  negative_o <= res_adj[WIDTH-1];
                  state      <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (ack_i) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign ready_o = (state == ST_IDLE);
   assign valid_o = (state == ST_DONE);

endmodule
